// File: rtl/spi_stream_pkg.sv
// -----------------------------------------------------------------------------
// spi_stream_pkg
// Shared types and default constants for the SPI sample streamer.
//   state_t : frame sequencing FSM states
//   widx_t  : which word of the frame is currently in the shift register
// -----------------------------------------------------------------------------
package spi_stream_pkg;

    localparam int          WORD_W_DEF      = 16;
    localparam logic [15:0] HEADER_WORD_DEF = 16'hA55A;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        SHIFT,
        LOAD,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        HDR,
        LEN,
        DATA,
        CSUM
    } widx_t;

endpackage

// File: rtl/sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Brings an asynchronous input into the clk domain through SYNC_STAGES flops
// and produces one-cycle rise/fall strobes from the last two stages.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-low reset (loads IDLE_LEVEL into every stage)
//   din  : asynchronous input
//   rise : one-cycle strobe on a 0->1 transition of the synchronized input
//   fall : one-cycle strobe on a 1->0 transition of the synchronized input
// -----------------------------------------------------------------------------
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic IDLE_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_p;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_p <= {SYNC_STAGES{IDLE_LEVEL}};
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], din};
        end
    end

    // Index SYNC_STAGES-2 is the newer of the two compared samples.
    assign rise =  sync_p[SYNC_STAGES-2] & ~sync_p[SYNC_STAGES-1];
    assign fall = ~sync_p[SYNC_STAGES-2] &  sync_p[SYNC_STAGES-1];

endmodule

// File: rtl/spi_sample_streamer.sv
// -----------------------------------------------------------------------------
// spi_sample_streamer
// Frames ADC samples as HEADER_WORD, length, data words (and an optional
// checksum) and shifts them out MSB first as an SPI mode-0 slave. sclk and
// SPI_cs are oversampled in the clk domain (sclk <= clk/8).
// Build option: define SPI_CHECKSUM_EN to append a sum-mod-2^WORD_W checksum
// of the data words; without it the frame ends after the last data word.
// Ports:
//   clk, rst          : system clock, synchronous active-low reset
//   sclk, SPI_cs      : SPI clock and active-low chip select (asynchronous)
//   frame_start       : pulse that arms a frame while idle
//   frame_len         : number of data words, latched on accepted frame_start
//   word_data/valid   : sample from memory and its valid flag
//   word_ready        : one-cycle pop strobe to memory
//   processed_MISO    : serial data out (0 while chip select is inactive)
//   transaction_done  : pulse after each complete word
//   SPI_RDY           : high while a frame is armed or in progress
//   frame_done        : pulse after the last word of the frame
//   underrun          : sticky, a fetch found word_valid low
// -----------------------------------------------------------------------------
module spi_sample_streamer
    import spi_stream_pkg::*;
#(
    parameter int                WORD_W      = WORD_W_DEF,
    parameter int                SYNC_STAGES = 2,
    parameter logic [WORD_W-1:0] HEADER_WORD = HEADER_WORD_DEF,
    parameter int                LEN_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              SPI_cs,
    input  logic              frame_start,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              processed_MISO,
    output logic              transaction_done,
    output logic              SPI_RDY,
    output logic              frame_done,
    output logic              underrun
);

    localparam int               CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    logic sclk_rise_raw, sclk_fall_raw;
    logic cs_rise, cs_fall;
    logic cs_active;
    logic sclk_rise, sclk_fall;

    state_t            state, state_nxt;
    widx_t             widx, widx_nxt;
    logic [WORD_W-1:0] shreg, cur_word, word_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  len_q, data_cnt;
    logic              fetch, word_last, underrun_q;

`ifdef SPI_CHECKSUM_EN
    logic [WORD_W-1:0] csum_q;

    function automatic logic [WORD_W-1:0] csum_add(input logic [WORD_W-1:0] acc,
                                                   input logic [WORD_W-1:0] val);
        return acc + val;
    endfunction
`endif

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (sclk),
        .rise (sclk_rise_raw),
        .fall (sclk_fall_raw)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI_cs),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Synchronized chip-select level, rebuilt from the strobes so it tracks
    // the last synchronizer stage exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_active <= 1'b0;
        end else if (cs_fall) begin
            cs_active <= 1'b1;
        end else if (cs_rise) begin
            cs_active <= 1'b0;
        end
    end

    // A chip-select release in the same cycle as an sclk edge discards the edge.
    assign sclk_rise = sclk_rise_raw & cs_active & ~cs_rise;
    assign sclk_fall = sclk_fall_raw & cs_active & ~cs_rise;

    // Next word selection. Data words are counted from zero, so the length
    // word and a data word share the "fetch another or finish" decision.
    always_comb begin
        widx_nxt  = widx;
        word_nxt  = cur_word;
        fetch     = 1'b0;
        word_last = 1'b0;
        unique case (widx)
            HDR: begin
                widx_nxt = LEN;
                word_nxt = WORD_W'(len_q);
            end
            LEN, DATA: begin
                if (data_cnt != len_q) begin
                    widx_nxt = DATA;
                    fetch    = 1'b1;
                    word_nxt = word_valid ? word_data : '0;
                end else begin
`ifdef SPI_CHECKSUM_EN
                    widx_nxt = CSUM;
                    word_nxt = csum_q;
`else
                    word_last = 1'b1;
`endif
                end
            end
            default: word_last = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        word_ready       = 1'b0;
        transaction_done = 1'b0;
        frame_done       = 1'b0;
        SPI_RDY          = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) state_nxt = ARMED;
            end
            ARMED: begin
                SPI_RDY = 1'b1;
                if (cs_fall) state_nxt = SHIFT;
            end
            SHIFT: begin
                SPI_RDY = 1'b1;
                if (sclk_rise && bit_cnt == LAST_BIT) state_nxt = LOAD;
            end
            LOAD: begin
                SPI_RDY          = 1'b1;
                transaction_done = 1'b1;
                word_ready       = fetch;
                state_nxt        = word_last ? DONE : SHIFT;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            widx       <= HDR;
            shreg      <= '0;
            cur_word   <= '0;
            bit_cnt    <= '0;
            len_q      <= '0;
            data_cnt   <= '0;
            underrun_q <= 1'b0;
`ifdef SPI_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        len_q      <= frame_len;
                        underrun_q <= 1'b0;
                        widx       <= HDR;
                        shreg      <= HEADER_WORD;
                        cur_word   <= HEADER_WORD;
                        bit_cnt    <= '0;
                        data_cnt   <= '0;
`ifdef SPI_CHECKSUM_EN
                        csum_q     <= '0;
`endif
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        // Partial word is abandoned; resend it from its MSB.
                        bit_cnt <= '0;
                        shreg   <= cur_word;
                    end else begin
                        if (sclk_rise) begin
                            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
                        end
                        // The fall before the first rise of a word must not shift.
                        if (sclk_fall && bit_cnt != '0) begin
                            shreg <= {shreg[WORD_W-2:0], 1'b0};
                        end
                    end
                end
                LOAD: begin
                    widx     <= widx_nxt;
                    shreg    <= word_nxt;
                    cur_word <= word_nxt;
                    if (fetch) begin
                        data_cnt <= data_cnt + 1'b1;
                        if (!word_valid) begin
                            underrun_q <= 1'b1;
                        end
`ifdef SPI_CHECKSUM_EN
                        if (word_valid) begin
                            csum_q <= csum_add(csum_q, word_data);
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign underrun       = underrun_q;
    assign processed_MISO = cs_active & SPI_RDY & shreg[WORD_W-1];

endmodule
